// File: rtl/inf_layer_sequencer_if.sv
// Control bundle between the frame source, the sequencer, the weight memory
// and the accumulating INF neuron. "master" drives frames; "slave" is the sequencer.
interface inf_layer_sequencer_if #(
    parameter int N_IN   = 20,
    parameter int N_OUT  = 10,
    parameter int ADDR_W = $clog2(N_IN * N_OUT),
    parameter int IDX_W  = (N_OUT > 1) ? $clog2(N_OUT) : 1
);
    logic              start;
    logic [N_IN-1:0]   spikes;
    logic              busy;
    logic [ADDR_W-1:0] weight_addr;
    logic              weight_rd_en;
    logic [IDX_W-1:0]  bias_idx;
    logic              load_en;
    logic              input_valid;
    logic              output_en;
    logic              out_valid;
    logic [IDX_W-1:0]  out_idx;
    logic              done;

    modport master (
        output start, spikes,
        input  busy, weight_addr, weight_rd_en, bias_idx, load_en,
               input_valid, output_en, out_valid, out_idx, done
    );

    modport slave (
        input  start, spikes,
        output busy, weight_addr, weight_rd_en, bias_idx, load_en,
               input_valid, output_en, out_valid, out_idx, done
    );
endinterface

// File: rtl/inf_layer_sequencer.sv
// Frame sequencer for the accumulating INF neuron: per output neuron it loads
// the bias, scans every input's weight (1-cycle read latency) and fires.
module inf_layer_sequencer #(
    parameter int N_IN   = 20,
    parameter int N_OUT  = 10,
    parameter int ADDR_W = $clog2(N_IN * N_OUT),
    parameter int IDX_W  = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    inf_layer_sequencer_if.slave bus
);
    localparam int CNT_W = $clog2(N_IN);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SCAN,
        DRAIN,
        FIRE
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [IDX_W-1:0]  r_n;
    logic [IDX_W-1:0]  w_next_n;
    logic [CNT_W-1:0]  r_idx;
    logic [CNT_W-1:0]  w_next_idx;
    logic [N_IN-1:0]   r_spk;
    logic              w_accept;
    logic [ADDR_W-1:0] w_next_addr;
    logic              w_next_spk;

    logic              r_busy;
    logic [ADDR_W-1:0] r_weight_addr;
    logic              r_weight_rd_en;
    logic [IDX_W-1:0]  r_bias_idx;
    logic              r_load_en;
    logic              r_input_valid;
    logic              r_output_en;
    logic              r_out_valid;
    logic [IDX_W-1:0]  r_out_idx;
    logic              r_done;

    assign w_accept = (r_state == IDLE) && bus.start;

    always_comb begin
        w_next_state = r_state;
        w_next_n     = r_n;
        w_next_idx   = r_idx;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_next_n     = '0;
                    w_next_state = LOAD;
                end
            end
            LOAD: begin
                w_next_idx   = '0;
                w_next_state = SCAN;
            end
            SCAN: begin
                if (r_idx == CNT_W'(N_IN - 1)) begin
                    w_next_state = DRAIN;
                end else begin
                    w_next_idx = r_idx + 1'b1;
                end
            end
            DRAIN: begin
                w_next_state = FIRE;
            end
            FIRE: begin
                if (r_n == IDX_W'(N_OUT - 1)) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_n     = r_n + 1'b1;
                    w_next_state = LOAD;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so each strobe is a flop that is
    // high exactly during the state it belongs to.
    always_comb begin
        w_next_addr = ADDR_W'(w_next_n) * ADDR_W'(N_IN) + ADDR_W'(w_next_idx);
        w_next_spk  = r_spk[w_next_idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_n     <= '0;
            r_idx   <= '0;
            r_spk   <= '0;
        end else begin
            r_state <= w_next_state;
            r_n     <= w_next_n;
            r_idx   <= w_next_idx;
            if (w_accept) begin
                r_spk <= bus.spikes;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy         <= 1'b0;
            r_weight_addr  <= '0;
            r_weight_rd_en <= 1'b0;
            r_bias_idx     <= '0;
            r_load_en      <= 1'b0;
            r_input_valid  <= 1'b0;
            r_output_en    <= 1'b0;
            r_out_valid    <= 1'b0;
            r_out_idx      <= '0;
            r_done         <= 1'b0;
        end else begin
            // Busy spans the trailing out_valid/done cycle after FIRE.
            r_busy         <= (w_next_state != IDLE) || r_output_en;
            r_load_en      <= (w_next_state == LOAD);
            r_bias_idx     <= (w_next_state == LOAD) ? w_next_n : '0;
            r_weight_addr  <= (w_next_state == SCAN) ? w_next_addr : '0;
            r_weight_rd_en <= (w_next_state == SCAN) && w_next_spk;
            r_input_valid  <= r_weight_rd_en;
            r_output_en    <= (w_next_state == FIRE);
            r_out_valid    <= r_output_en;
            r_out_idx      <= r_output_en ? r_n : '0;
            r_done         <= r_output_en && (r_n == IDX_W'(N_OUT - 1));
        end
    end

    assign bus.busy         = r_busy;
    assign bus.weight_addr  = r_weight_addr;
    assign bus.weight_rd_en = r_weight_rd_en;
    assign bus.bias_idx     = r_bias_idx;
    assign bus.load_en      = r_load_en;
    assign bus.input_valid  = r_input_valid;
    assign bus.output_en    = r_output_en;
    assign bus.out_valid    = r_out_valid;
    assign bus.out_idx      = r_out_idx;
    assign bus.done         = r_done;
endmodule

// File: tb/tb_inf_layer_sequencer.sv
// Bench for inf_layer_sequencer with a behavioural weight memory (weight=addr+1)
// and accumulating neuron; expectations come from the per-frame timing rules.
module tb_inf_layer_sequencer;
    localparam int N_IN  = 4;
    localparam int N_OUT = 2;
    localparam int PER   = N_IN + 3;
    localparam int LAST  = N_OUT * PER + 1;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   bias [N_OUT];
    int   acc;
    int   wdata;
    int   out_vol;

    inf_layer_sequencer_if #(.N_IN(N_IN), .N_OUT(N_OUT)) bus ();

    inf_layer_sequencer #(.N_IN(N_IN), .N_OUT(N_OUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (rst) begin
            acc     <= 0;
            wdata   <= 0;
            out_vol <= 0;
        end else begin
            if (bus.weight_rd_en) wdata <= int'(bus.weight_addr) + 1;
            if (bus.load_en) acc <= bias[bus.bias_idx];
            else if (bus.input_valid) acc <= acc + wdata;
            if (bus.output_en) out_vol <= acc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_vol(input int k, input logic [N_IN-1:0] s);
        int v;
        v = bias[k];
        for (int i = 0; i < N_IN; i++) if (s[i]) v += k * N_IN + i + 1;
        return v;
    endfunction

    task automatic check_idle(input string tag, input bit full);
        chk({tag, " busy"}, 32'(bus.busy), 0);
        chk({tag, " load_en"}, 32'(bus.load_en), 0);
        chk({tag, " rd_en"}, 32'(bus.weight_rd_en), 0);
        chk({tag, " input_valid"}, 32'(bus.input_valid), 0);
        chk({tag, " output_en"}, 32'(bus.output_en), 0);
        chk({tag, " out_valid"}, 32'(bus.out_valid), 0);
        chk({tag, " done"}, 32'(bus.done), 0);
        if (full) begin
            chk({tag, " addr"}, 32'(bus.weight_addr), 0);
            chk({tag, " bias_idx"}, 32'(bus.bias_idx), 0);
            chk({tag, " out_idx"}, 32'(bus.out_idx), 0);
        end
    endtask

    // Cycle c counts from 1 = first cycle after the accepted start edge.
    task automatic check_cycle(input int c, input logic [N_IN-1:0] s);
        int k, o;
        bit e_load, e_scan, e_rd, e_iv, e_oe, e_ov, e_done;
        string t;
        k = (c - 1) / PER;
        o = (c - 1) % PER;
        t = $sformatf("c%0d", c);
        e_load = (k < N_OUT) && (o == 0);
        e_scan = (k < N_OUT) && (o >= 1) && (o <= N_IN);
        e_rd   = 1'b0;
        if (e_scan) e_rd = s[o-1];
        e_iv   = 1'b0;
        if ((k < N_OUT) && (o >= 2) && (o <= N_IN + 1)) e_iv = s[o-2];
        e_oe   = (k < N_OUT) && (o == N_IN + 2);
        e_ov   = (c > 1) && (o == 0);
        e_done = (c == LAST);
        chk({t, " busy"}, 32'(bus.busy), 1);
        chk({t, " load_en"}, 32'(bus.load_en), 32'(e_load));
        chk({t, " rd_en"}, 32'(bus.weight_rd_en), 32'(e_rd));
        chk({t, " input_valid"}, 32'(bus.input_valid), 32'(e_iv));
        chk({t, " output_en"}, 32'(bus.output_en), 32'(e_oe));
        chk({t, " out_valid"}, 32'(bus.out_valid), 32'(e_ov));
        chk({t, " done"}, 32'(bus.done), 32'(e_done));
        if (e_load) chk({t, " bias_idx"}, 32'(bus.bias_idx), 32'(k));
        if (e_scan) chk({t, " addr"}, 32'(bus.weight_addr), 32'(k * N_IN + o - 1));
        if (e_ov) begin
            chk({t, " out_idx"}, 32'(bus.out_idx), 32'(k - 1));
            chk({t, " out_vol"}, 32'(out_vol), 32'(exp_vol(k - 1, s)));
        end
    endtask

    // Caller raises start with the frame's spikes just before calling.
    task automatic run_frame(input logic [N_IN-1:0] s, input int ncyc, input bit disturb);
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            if (c == 1) bus.start = 1'b0;
            check_cycle(c, s);
            if (disturb && c == 3) begin
                bus.start  = 1'b1;
                bus.spikes = ~s;
            end
            if (disturb && c == 4) begin
                bus.start  = 1'b0;
                bus.spikes = N_IN'($urandom);
            end
        end
    endtask

    initial begin
        logic [N_IN-1:0] sp;
        checks     = 0;
        errors     = 0;
        bias[0]    = 100;
        bias[1]    = 200;
        rst        = 1'b1;
        bus.start  = 1'b1;
        bus.spikes = '1;

        // Reset with start held
        repeat (3) begin
            @(negedge clk);
            check_idle("rst", 1'b1);
        end
        rst       = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        check_idle("post_rst", 1'b1);

        // Spikes 1011: reads at 0,1,3 / 4,5,7; outputs 107 and 219
        sp = 4'b1011;
        bus.spikes = sp;
        bus.start  = 1'b1;
        run_frame(sp, LAST, 1'b0);
        chk("f1 vol1", 32'(out_vol), 219);
        @(negedge clk);
        check_idle("f1_after", 1'b0);

        // All-zero spikes: outputs equal biases
        sp = '0;
        bus.spikes = sp;
        bus.start  = 1'b1;
        run_frame(sp, LAST, 1'b0);
        chk("f2 vol1", 32'(out_vol), 200);
        @(negedge clk);
        check_idle("f2_after", 1'b0);

        // All ones, next frame started in the done cycle
        sp = '1;
        bus.spikes = sp;
        bus.start  = 1'b1;
        run_frame(sp, LAST, 1'b0);
        sp = 4'b1011;
        bus.spikes = sp;
        bus.start  = 1'b1;
        run_frame(sp, LAST, 1'b0);
        @(negedge clk);
        check_idle("chain_after", 1'b0);

        // Start and spike changes mid-frame are ignored
        sp = 4'b0110;
        bus.spikes = sp;
        bus.start  = 1'b1;
        run_frame(sp, LAST, 1'b1);
        @(negedge clk);
        check_idle("disturb_after", 1'b0);

        // Reset during SCAN of neuron 1 aborts the frame
        sp = 4'b1101;
        bus.spikes = sp;
        bus.start  = 1'b1;
        run_frame(sp, 10, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check_idle("abort", 1'b1);
        rst = 1'b0;
        repeat (8) begin
            @(negedge clk);
            check_idle("abort_quiet", 1'b0);
        end
        sp = 4'b0101;
        bus.spikes = sp;
        bus.start  = 1'b1;
        run_frame(sp, LAST, 1'b0);

        // Randomized frames, alternately chained and separated
        for (int r = 0; r < 8; r++) begin
            bias[0]    = int'($urandom_range(0, 1000));
            bias[1]    = int'($urandom_range(0, 1000));
            sp         = N_IN'($urandom);
            bus.spikes = sp;
            bus.start  = 1'b1;
            run_frame(sp, LAST, bit'(r % 3 == 2));
            if (r % 2 == 1) begin
                @(negedge clk);
                check_idle("rand_gap", 1'b0);
            end
        end
        @(negedge clk);
        check_idle("end", 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
